// File: rtl/fixture_sequencer_if.sv
// fixture_sequencer_if: control, status and DUT loopback bundle.
// master = fixture/test side, slave = the sequencer itself.
interface fixture_sequencer_if #(
    parameter int DATA_W = 12,
    parameter int CNT_W  = 8
);
    logic              start;
    logic [3:0]        rst_cycles;
    logic [CNT_W-1:0]  run_cycles;
    logic              busy;
    logic              done;
    logic              dut_sync_rst;
    logic              dut_async_rst;
    logic [DATA_W-1:0] dut_bus_out;
    logic [DATA_W-1:0] dut_bus_in;
    logic [CNT_W-1:0]  dut_count_in;
    logic              err;
    logic [CNT_W-1:0]  err_count;

    modport master (
        output start, rst_cycles, run_cycles,
        output dut_bus_in, dut_count_in,
        input  busy, done, dut_sync_rst, dut_async_rst,
        input  dut_bus_out, err, err_count
    );

    modport slave (
        input  start, rst_cycles, run_cycles,
        input  dut_bus_in, dut_count_in,
        output busy, done, dut_sync_rst, dut_async_rst,
        output dut_bus_out, err, err_count
    );
endinterface

// File: rtl/fixture_sequencer.sv
// fixture_sequencer: reset / run / check sequence for a loopback DUT.
// Loopback and counter checking is built only with FIXTURE_SEQ_CHECK_EN.
module fixture_sequencer #(
    parameter int DATA_W = 12,
    parameter int CNT_W  = 8
) (
    input logic              clk,
    input logic              async_rst,
    fixture_sequencer_if.slave io
);
    localparam int CW = (CNT_W > 4) ? CNT_W : 4;

    typedef enum logic [2:0] {
        IDLE, ASSERT_RST, RUN, CHECK, DONE
    } state_e;

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [CNT_W-1:0]  run_q, run_d;
    logic [DATA_W-1:0] bus_q, bus_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              rst_q, rst_d;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  errc_q, errc_d;
    logic [CW-1:0]     n_eff;

    // A hold length of zero still gives the DUT one reset cycle.
    always_comb begin
        n_eff = CW'(io.rst_cycles);
        if (io.rst_cycles == 4'd0) n_eff = CW'(1);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        run_d   = run_q;
        unique case (state_q)
            IDLE: begin
                if (io.start) begin
                    state_d = ASSERT_RST;
                    cnt_d   = n_eff - CW'(1);
                    run_d   = io.run_cycles;
                end
            end
            ASSERT_RST: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else if (run_q == '0) begin
                    state_d = CHECK;
                end else begin
                    state_d = RUN;
                    cnt_d   = CW'(run_q) - CW'(1);
                end
            end
            RUN: begin
                if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
                else             state_d = CHECK;
            end
            CHECK:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Outputs are decoded from the next state so they register cleanly.
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
        rst_d  = (state_d == ASSERT_RST);
        bus_d  = '0;
        if (state_d == RUN && state_q == RUN) bus_d = bus_q + 1'b1;
    end

`ifdef FIXTURE_SEQ_CHECK_EN
    logic mis;

    always_comb begin
        mis = 1'b0;
        if (state_q == RUN)   mis = (io.dut_bus_in != bus_q);
        if (state_q == CHECK) mis = (io.dut_count_in != run_q);
        errc_d = errc_q;
        if (state_q == IDLE && io.start)  errc_d = '0;
        else if (mis && errc_q != '1)     errc_d = errc_q + 1'b1;
        err_d = (errc_d != '0);
    end
`else
    logic unused_loopback;
    assign unused_loopback = ^{io.dut_bus_in, io.dut_count_in};

    always_comb begin
        errc_d = '0;
        err_d  = 1'b0;
    end
`endif

    always_ff @(posedge clk or posedge async_rst) begin
        if (async_rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            run_q   <= '0;
            bus_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            rst_q   <= 1'b0;
            err_q   <= 1'b0;
            errc_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            run_q   <= run_d;
            bus_q   <= bus_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            rst_q   <= rst_d;
            err_q   <= err_d;
            errc_q  <= errc_d;
        end
    end

    assign io.busy          = busy_q;
    assign io.done          = done_q;
    assign io.dut_sync_rst  = rst_q;
    assign io.dut_async_rst = rst_q;
    assign io.dut_bus_out   = bus_q;
    assign io.err           = err_q;
    assign io.err_count     = errc_q;
endmodule

// File: tb/tb_fixture_sequencer.sv
// tb_fixture_sequencer: timeline model of the sequencer plus a
// loopback DUT stand-in with an optional stuck-at-0 fault on bit 0.
module tb_fixture_sequencer;
    localparam int DW = 4;
    localparam int CW = 8;
`ifdef FIXTURE_SEQ_CHECK_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif
    localparam logic [DW-1:0] BIT0_CLR = ~DW'(1);

    logic clk = 1'b0;
    logic async_rst = 1'b1;
    logic fault = 1'b0;

    fixture_sequencer_if #(.DATA_W(DW), .CNT_W(CW)) io ();

    fixture_sequencer #(.DATA_W(DW), .CNT_W(CW)) dut (
        .clk       (clk),
        .async_rst (async_rst),
        .io        (io)
    );

    always #5 clk = ~clk;

    assign io.dut_bus_in = fault ? (io.dut_bus_out & BIT0_CLR)
                                 : io.dut_bus_out;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input longint act,
                       input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d want %0d", nm, act, exp);
    endtask

    // Model: mt = cycle index since acceptance (0 = idle).
    int mt = 0;
    int mn = 0;
    int mr = 0;
    int mec = 0;
    bit pend = 1'b0;

    function automatic int neff();
        return (mn == 0) ? 1 : mn;
    endfunction

    function automatic int e_bus();
        int ne;
        ne = neff();
        if (mt > ne && mt <= ne + mr) return (mt - ne - 1) % (1 << DW);
        return 0;
    endfunction

    always @(posedge clk or posedge async_rst) begin
        if (async_rst) begin
            mt = 0;
            mec = 0;
        end else if (mt == 0) begin
            if (io.start) begin
                mt = 1;
                mn = int'(io.rst_cycles);
                mr = int'(io.run_cycles);
                mec = 0;
            end
        end else begin
            if (pend && mec < 255) mec++;
            if (mt == neff() + mr + 2) mt = 0;
            else mt++;
        end
    end

    // DUT stand-in counter: cleared by a reset cycle, else counts.
    logic [CW-1:0] cnt_v = '0;
    logic prev_sync = 1'b0;

    always @(negedge clk) begin
        int ne;
        cnt_v = prev_sync ? '0 : cnt_v + 1'b1;
        prev_sync = io.dut_sync_rst;
        io.dut_count_in = cnt_v;
        ne = neff();
        chk("busy", io.busy, mt != 0);
        chk("done", io.done, mt != 0 && mt == ne + mr + 2);
        chk("sync_rst", io.dut_sync_rst, mt >= 1 && mt <= ne);
        chk("async_rst", io.dut_async_rst, mt >= 1 && mt <= ne);
        chk("bus_out", io.dut_bus_out, e_bus());
        chk("err", io.err, CHK_EN && mec != 0);
        chk("err_count", io.err_count, CHK_EN ? mec : 0);
        pend = 1'b0;
        if (mt > ne && mt <= ne + mr && int'(io.dut_bus_in) != e_bus())
            pend = 1'b1;
        if (mt == ne + mr + 1 && int'(io.dut_count_in) != (mr % 256))
            pend = 1'b1;
    end

    int bus_at [64];
    int rst_at [64];
    int ec_at  [64];

    task automatic run_seq(input int n, input int r, input bit hold,
                           output int lat, output int ec, output bit er);
        lat = -1;
        ec = -1;
        er = 1'b0;
        @(negedge clk); #1;
        io.start = 1'b1;
        io.rst_cycles = 4'(n);
        io.run_cycles = CW'(r);
        @(posedge clk); #1;
        io.start = hold;
        for (int i = 1; i < 400; i++) begin
            @(negedge clk);
            if (i < 64) begin
                bus_at[i] = int'(io.dut_bus_out);
                rst_at[i] = int'(io.dut_sync_rst);
                ec_at[i]  = int'(io.err_count);
            end
            if (io.done) begin
                lat = i;
                ec = int'(io.err_count);
                er = io.err;
                break;
            end
        end
    endtask

    initial begin
        int lat, ec, dones;
        bit er;
        io.start = 1'b0;
        io.rst_cycles = '0;
        io.run_cycles = '0;
        #2;
        chk("rst_busy", io.busy, 0);
        chk("rst_bus", io.dut_bus_out, 0);
        chk("rst_errc", io.err_count, 0);
        repeat (2) @(negedge clk);
        #1 async_rst = 1'b0;

        run_seq(3, 10, 1'b0, lat, ec, er);
        chk("nom_lat", lat, 15);
        chk("nom_rst3", rst_at[3], 1);
        chk("nom_rst4", rst_at[4], 0);
        chk("nom_bus4", bus_at[4], 0);
        chk("nom_bus13", bus_at[13], 9);
        chk("nom_err", er, 0);

        run_seq(0, 0, 1'b0, lat, ec, er);
        chk("zero_lat", lat, 3);
        chk("zero_err", er, 0);

        run_seq(2, 20, 1'b0, lat, ec, er);
        chk("wrap_lat", lat, 24);
        chk("wrap_bus18", bus_at[18], 15);
        chk("wrap_bus19", bus_at[19], 0);
        chk("wrap_bus22", bus_at[22], 3);
        chk("wrap_errc", ec, 0);

        fault = 1'b1;
        run_seq(1, 6, 1'b0, lat, ec, er);
        fault = 1'b0;
        chk("fault_lat", lat, 9);
        chk("fault_errc", ec, CHK_EN ? 3 : 0);
        chk("fault_err", er, CHK_EN);
        run_seq(1, 2, 1'b0, lat, ec, er);
        chk("clear_errc", ec_at[1], 0);
        chk("clear_err", er, 0);

        @(negedge clk); #1;
        io.start = 1'b1;
        io.rst_cycles = 4'd3;
        io.run_cycles = CW'(10);
        @(posedge clk); #1;
        io.start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk); #1;
        chk("mid_bus_pre", io.dut_bus_out, 1);
        async_rst = 1'b1;
        #1;
        chk("mid_busy", io.busy, 0);
        chk("mid_bus", io.dut_bus_out, 0);
        chk("mid_sync", io.dut_sync_rst, 0);
        chk("mid_arst", io.dut_async_rst, 0);
        @(negedge clk); #1;
        async_rst = 1'b0;
        dones = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (io.done) dones++;
        end
        chk("mid_nodone", dones, 0);
        run_seq(2, 5, 1'b0, lat, ec, er);
        chk("post_lat", lat, 9);

        run_seq(1, 2, 1'b1, lat, ec, er);
        chk("hold_lat", lat, 5);
        @(negedge clk);
        chk("hold_idle", io.busy, 0);
        @(negedge clk);
        chk("hold_again", io.busy, 1);
        #1 io.start = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!io.busy) break;
        end

        for (int c = 0; c < 2500; c++) begin
            @(negedge clk); #1;
            io.start = ($urandom_range(3) == 0);
            io.rst_cycles = 4'($urandom_range(15));
            io.run_cycles = CW'($urandom_range(30));
            if ($urandom_range(40) == 0) fault = ~fault;
            if ($urandom_range(300) == 0) begin
                async_rst = 1'b1;
                #2 async_rst = 1'b0;
            end
        end
        @(negedge clk); #1;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/fixture_sequencer.md
FIXTURE_SEQUENCER -- requirements
Module: fixture_sequencer

Interface
REQ-001 Parameter DATA_W, default 12: width of the stimulus/loopback bus.
REQ-002 Parameter CNT_W, default 8: width of the DUT cycle counter and run-length field.
REQ-003 Port clk  in  1  clock; all state updates occur on posedge clk.
REQ-004 Port async_rst  in  1  reset, asynchronous, active-high.
REQ-005 Port start  in  1  request one test sequence; sampled only in IDLE.
REQ-006 Port rst_cycles  in  4  DUT reset hold length N, sampled with start.
REQ-007 Port run_cycles  in  CNT_W  DUT run length R, sampled with start.
REQ-008 Port busy  out  1  high in every state except IDLE.
REQ-009 Port done  out  1  single-cycle completion pulse.
REQ-010 Port dut_sync_rst  out  1  synchronous reset drive to the DUT.
REQ-011 Port dut_async_rst  out  1  asynchronous reset drive to the DUT.
REQ-012 Port dut_bus_out  out  DATA_W  stimulus pattern driven to the DUT input bus.
REQ-013 Port dut_bus_in  in  DATA_W  DUT output bus, the loopback of dut_bus_out.
REQ-014 Port dut_count_in  in  CNT_W  DUT synchronous-reset cycle counter value.
REQ-015 Port err  out  1  sticky failure flag for the current sequence.
REQ-016 Port err_count  out  CNT_W  saturating mismatch count.

Function
REQ-017 FSM states SHALL be IDLE, ASSERT_RST, RUN, CHECK and DONE; all outputs SHALL be registered.
REQ-018 IDLE with start=1 SHALL latch N and R, clear err/err_count, and go to ASSERT_RST; start in any other state SHALL be ignored.
REQ-019 N=0 SHALL be treated as N=1.
REQ-020 ASSERT_RST SHALL last exactly N cycles with dut_sync_rst=1 and dut_async_rst=1, then go to RUN, or to CHECK if R=0.
REQ-021 RUN SHALL last exactly R cycles with both DUT resets low, then go to CHECK.
REQ-022 dut_bus_out SHALL be 0 in the first RUN cycle and increment by 1 each RUN cycle, wrapping modulo 2^DATA_W; it SHALL be held at 0 outside RUN.
REQ-023 CHECK SHALL last one cycle, then go to DONE; DONE SHALL last one cycle with done=1, then go to IDLE.
REQ-024 Taking the acceptance edge as cycle 0, ASSERT_RST occupies cycles 1..N, RUN occupies N+1..N+R, CHECK is N+R+1 and done=1 is in cycle N+R+2.
REQ-025 start=1 in the cycle done=1 SHALL NOT be accepted; acceptance occurs from IDLE only, so the earliest is the following cycle.

Reset
REQ-026 async_rst=1 SHALL immediately force IDLE with busy=0, done=0, dut_sync_rst=0, dut_async_rst=0, dut_bus_out=0, err=0 and err_count=0, including mid-sequence.
REQ-027 After async_rst deasserts, the block SHALL accept start on the first posedge clk where start=1.

Configuration
REQ-028 With macro FIXTURE_SEQ_CHECK_EN defined, the block SHALL check every RUN cycle; dut_bus_in!=dut_bus_out SHALL increment err_count, saturating at 2^CNT_W-1.
REQ-029 With FIXTURE_SEQ_CHECK_EN defined, CHECK SHALL count a mismatch if dut_count_in != R mod 2^CNT_W.
REQ-030 With FIXTURE_SEQ_CHECK_EN defined, err SHALL be set when err_count is nonzero and SHALL stay set until the next accepted start or reset.
REQ-031 With FIXTURE_SEQ_CHECK_EN undefined, err and err_count SHALL be constant 0, while state sequence and timing stay identical.

Verification
REQ-032 Nominal: N=3, R=10, ideal loopback DUT -> resets high in cycles 1-3, bus 0..9 in cycles 4-13, done in cycle 15, err=0.
REQ-033 Boundaries: N=0, R=0 -> one reset cycle, no RUN, CHECK sees count 0, done in cycle 3, err=0.
REQ-034 Wrap: DATA_W=4, R=20 -> bus sequence 0..15 then 0..3; CHECK expects count 20, err=0.
REQ-035 Fault (macro on): force dut_bus_in bit0 stuck at 0, R=6 -> err_count=3, err=1 at done; next start clears both.
REQ-036 Reset mid-RUN: pulse async_rst in cycle N+2 -> all outputs 0 at once, done never pulses, a new start works normally.
REQ-037 start held high through a whole sequence -> no acceptance while busy=1; the next sequence begins one cycle after the done pulse.
